// File: rtl/neogeo_m68k_pkg.sv
// Shared types for the 68000 bus-cycle controller: bus FSM states and the
// interrupt-acknowledge function code.
package neogeo_m68k_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CNT = 3'd1,
    WAIT_EXT = 3'd2,
    ACK      = 3'd3,
    ACK_VPA  = 3'd4,
    BERR     = 3'd5
  } bus_state_t;

  localparam logic [2:0] FC_IACK = 3'b111;

  function automatic logic is_wait(input bus_state_t s);
    return (s == WAIT_CNT) || (s == WAIT_EXT);
  endfunction

endpackage

// File: rtl/m68k_clken_gen.sv
// PHI1/PHI2 clock-enable divider for the fx68k core plus a CPU reset
// stretcher that releases on a PHI2 enable after RESET_HOLD PHI2 pulses.
module m68k_clken_gen #(
  parameter int DIV        = 2,
  parameter int RESET_HOLD = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pause,
  output logic o_en_phi1,
  output logic o_en_phi2,
  output logic o_cpu_reset
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(DIV / 2 - 1);
  localparam int HW = $clog2(RESET_HOLD + 1) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((RESET_HOLD == 0) ? 0 : RESET_HOLD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_en_phi1;
  logic          r_en_phi2;
  logic [HW-1:0] r_hold;
  logic          r_cpu_reset;

  // Pause keeps the phase counter, so the enable pattern resumes where it stopped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_en_phi1 <= 1'b0;
      r_en_phi2 <= 1'b0;
    end else if (i_pause) begin
      r_en_phi1 <= 1'b0;
      r_en_phi2 <= 1'b0;
    end else begin
      r_cnt     <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
      r_en_phi2 <= (r_cnt == CNT_MID);
      r_en_phi1 <= (r_cnt == CNT_LAST);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold      <= '0;
      r_cpu_reset <= 1'b1;
    end else if (r_cpu_reset && r_en_phi2) begin
      r_hold <= r_hold + HW'(1);
      if (r_hold == HOLD_LAST) r_cpu_reset <= 1'b0;
    end
  end

  assign o_en_phi1   = r_en_phi1;
  assign o_en_phi2   = r_en_phi2;
  assign o_cpu_reset = r_cpu_reset;

endmodule

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle controller: clock enables, CPU reset, and termination of
// each bus cycle with DTACK, autovector VPA or BERR on timeout.
module m68k_bus_ctrl
  import neogeo_m68k_pkg::*;
#(
  parameter int                     DIV          = 2,
  parameter int                     NUM_REGIONS  = 8,
  parameter int                     WAIT_W       = 4,
  parameter logic [NUM_REGIONS-1:0] EXT_MASK     = '0,
  parameter int                     TIMEOUT      = 255,
  parameter int                     RESET_HOLD   = 16,
  parameter int                     AUTOVEC_MODE = 0
) (
  input  logic                            CLK_24M,
  input  logic                            RESET,
  input  logic                            PAUSE,
  output logic                            EN_PHI1,
  output logic                            EN_PHI2,
  output logic                            CPU_RESET,
  input  logic                            nAS,
  input  logic [22:0]                     M68K_ADDR,
  input  logic [2:0]                      FC,
  input  logic                            IPL2n,
  input  logic [$clog2(NUM_REGIONS)-1:0]  REGION_SEL,
  input  logic [NUM_REGIONS*WAIT_W-1:0]   WAIT_CFG,
  input  logic                            EXT_ACK,
  output logic                            nDTACK,
  output logic                            nVPA,
  output logic                            nBERR,
  output logic [22:0]                     BERR_ADDR
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic                   w_en_phi2;
  bus_state_t             r_state;
  bus_state_t             w_state_nxt;
  logic [WAIT_W-1:0]      r_wcnt;
  logic [TW-1:0]          r_tcnt;
  logic [WAIT_W-1:0]      w_field;
  logic [NUM_REGIONS-1:0] w_ext_mask;
  logic                   w_iack;
  logic                   w_wdone;
  logic                   w_tdone;
  logic                   w_ndtack;
  logic                   w_nvpa;
  logic                   w_nberr;
  logic                   w_berr_latch;
  logic                   r_ndtack;
  logic                   r_nvpa;
  logic                   r_nberr;
  logic [22:0]            r_berr_addr;

  m68k_clken_gen #(
    .DIV        (DIV),
    .RESET_HOLD (RESET_HOLD)
  ) u_clken (
    .i_clk       (CLK_24M),
    .i_rst       (RESET),
    .i_pause     (PAUSE),
    .o_en_phi1   (EN_PHI1),
    .o_en_phi2   (w_en_phi2),
    .o_cpu_reset (CPU_RESET)
  );

  assign EN_PHI2    = w_en_phi2;
  assign w_ext_mask = EXT_MASK;
  assign w_field    = WAIT_CFG[REGION_SEL*WAIT_W +: WAIT_W];
  // Autovector detect: interrupt acknowledge space at the top of the address map.
  assign w_iack     = (AUTOVEC_MODE != 0) ? (FC == FC_IACK)
                                          : (!IPL2n && (&M68K_ADDR[22:3]));
  assign w_wdone    = w_en_phi2 && (r_wcnt <= WAIT_W'(1));
  assign w_tdone    = (TIMEOUT != 0) && w_en_phi2 && (r_tcnt == TCNT_LAST);

  always_ff @(posedge CLK_24M) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Abort beats everything; a same-cycle ack beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!nAS) begin
          if (w_iack)                      w_state_nxt = ACK_VPA;
          else if (w_ext_mask[REGION_SEL]) w_state_nxt = WAIT_EXT;
          else if (w_field == '0)          w_state_nxt = ACK;
          else                             w_state_nxt = WAIT_CNT;
        end
      end
      WAIT_CNT: begin
        if (nAS)          w_state_nxt = IDLE;
        else if (w_wdone) w_state_nxt = ACK;
        else if (w_tdone) w_state_nxt = BERR;
      end
      WAIT_EXT: begin
        if (nAS)          w_state_nxt = IDLE;
        else if (EXT_ACK) w_state_nxt = ACK;
        else if (w_tdone) w_state_nxt = BERR;
      end
      ACK, ACK_VPA, BERR: begin
        if (nAS) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ndtack     = (r_state != ACK);
    w_nvpa       = (r_state != ACK_VPA);
    w_nberr      = (r_state != BERR);
    w_berr_latch = is_wait(r_state) && (w_state_nxt == BERR);
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_wcnt <= '0;
      r_tcnt <= '0;
    end else if (r_state == IDLE) begin
      if (!nAS) begin
        r_wcnt <= w_field;
        r_tcnt <= '0;
      end
    end else if (is_wait(r_state) && w_en_phi2) begin
      r_tcnt <= r_tcnt + TW'(1);
      if (r_state == WAIT_CNT && r_wcnt != '0) r_wcnt <= r_wcnt - WAIT_W'(1);
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_ndtack    <= 1'b1;
      r_nvpa      <= 1'b1;
      r_nberr     <= 1'b1;
      r_berr_addr <= '0;
    end else begin
      r_ndtack <= w_ndtack;
      r_nvpa   <= w_nvpa;
      r_nberr  <= w_nberr;
      if (w_berr_latch) r_berr_addr <= M68K_ADDR;
    end
  end

  assign nDTACK    = r_ndtack;
  assign nVPA      = r_nvpa;
  assign nBERR     = r_nberr;
  assign BERR_ADDR = r_berr_addr;

endmodule
